// File: rtl/sc_decode_scheduler.sv
// ----------------------------------------------------------------------------
// sc_decode_scheduler
//
// Sequences one successive-cancellation (SC) polar decode over a code of
// length N = 2^log_n. The block walks the SC tree leaf by leaf and issues
// F, G and LEAF ops to the LLR datapath over a valid/ready handshake. It
// collects each decided bit u_i from the decision unit, forwards it to the
// partial-sum generator with its index and fold depth, and pulses done
// after the final bit has been decided.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      begin a decode (only looked at while idle)
//   log_n      in   STG_W  log2 of the code length, captured on start
//   abort      in   1      synchronous abandon, returns to idle next edge
//   op_valid   out  1      an op is presented on op_type/op_stage/bit_idx
//   op_ready   in   1      datapath takes the presented op this cycle
//   op_type    out  2      0=F, 1=G, 2=LEAF
//   op_stage   out  STG_W  tree stage of the op (0 for LEAF)
//   bit_idx    out  IDX_W  index of the leaf currently being decoded
//   u_valid    in   1      decision unit returns the decided bit
//   u_bit      in   1      decided bit value
//   ps_valid   out  1      one-cycle partial-sum update request
//   ps_u       out  1      bit to fold into the partial sums
//   ps_depth   out  STG_W  number of fold levels (trailing ones of index)
//   ps_idx     out  IDX_W  index of the bit being folded
//   busy       out  1      high whenever a decode is in progress
//   done       out  1      one-cycle pulse at decode completion
// ----------------------------------------------------------------------------
module sc_decode_scheduler #(
    parameter int MAX_LOG_N = 9,
    parameter int STG_W     = 4,
    parameter int IDX_W     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [STG_W-1:0] log_n,
    input  logic             abort,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [1:0]       op_type,
    output logic [STG_W-1:0] op_stage,
    output logic [IDX_W-1:0] bit_idx,
    input  logic             u_valid,
    input  logic             u_bit,
    output logic             ps_valid,
    output logic             ps_u,
    output logic [STG_W-1:0] ps_depth,
    output logic [IDX_W-1:0] ps_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_F,
        ISSUE_G,
        ISSUE_LEAF,
        WAIT_U,
        PS_UPD,
        FIN
    } state_t;

    localparam logic [1:0] OP_F    = 2'd0;
    localparam logic [1:0] OP_G    = 2'd1;
    localparam logic [1:0] OP_LEAF = 2'd2;

    state_t             state;
    logic [STG_W-1:0]   n_reg;
    logic [IDX_W:0]     n_size;
    logic               is_last;
    logic               accepted;
    logic               start_ok;
    logic [IDX_W-1:0]   next_idx;

    // Trailing-zero count. The trailing-ones count of a value is the
    // trailing-zero count of its complement, so one helper serves both the
    // G stage selection and the partial-sum fold depth.
    function automatic logic [STG_W-1:0] count_tz(input logic [IDX_W-1:0] v);
        logic [STG_W-1:0] c;
        logic             found;
        c     = '0;
        found = 1'b0;
        for (int k = 0; k < IDX_W; k++) begin
            if (!found) begin
                if (v[k]) begin
                    found = 1'b1;
                end else begin
                    c = c + STG_W'(1);
                end
            end
        end
        return c;
    endfunction

    // N is computed one bit wider than the index so that N = 2^MAX_LOG_N
    // still fits; the last leaf is the one whose index equals N-1.
    assign n_size   = (IDX_W+1)'(1) << n_reg;
    assign is_last  = ({1'b0, bit_idx} == (n_size - (IDX_W+1)'(1)));
    assign accepted = op_valid & op_ready;
    assign next_idx = bit_idx + IDX_W'(1);
    assign start_ok = (log_n != '0) && (log_n <= STG_W'(MAX_LOG_N));

    // Main scheduler FSM. Every output is a register loaded on the same edge
    // that enters the state producing it, so an op is presented for as long
    // as the FSM sits in an ISSUE state and its fields only move once the
    // datapath has taken it. The leaf index doubles as the bit_idx output and
    // the current stage lives directly in op_stage. abort is checked ahead of
    // the state decode so it wins over start, op_ready and u_valid alike.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            n_reg    <= '0;
            op_valid <= 1'b0;
            op_type  <= OP_F;
            op_stage <= '0;
            bit_idx  <= '0;
            ps_valid <= 1'b0;
            ps_u     <= 1'b0;
            ps_depth <= '0;
            ps_idx   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (abort) begin
            state    <= IDLE;
            n_reg    <= '0;
            op_valid <= 1'b0;
            op_type  <= OP_F;
            op_stage <= '0;
            bit_idx  <= '0;
            ps_valid <= 1'b0;
            ps_u     <= 1'b0;
            ps_depth <= '0;
            ps_idx   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && start_ok) begin
                        // Leaf 0 descends from the root: F at n-1 down to 0.
                        n_reg    <= log_n;
                        bit_idx  <= '0;
                        op_type  <= OP_F;
                        op_stage <= log_n - STG_W'(1);
                        op_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE_F;
                    end
                end

                ISSUE_F: begin
                    if (accepted) begin
                        if (op_stage == '0) begin
                            op_type  <= OP_LEAF;
                            op_stage <= '0;
                            state    <= ISSUE_LEAF;
                        end else begin
                            op_stage <= op_stage - STG_W'(1);
                        end
                    end
                end

                ISSUE_G: begin
                    // A G at stage t is followed by F at t-1..0; at t=0 the
                    // G lands directly on the leaf.
                    if (accepted) begin
                        if (op_stage == '0) begin
                            op_type  <= OP_LEAF;
                            op_stage <= '0;
                            state    <= ISSUE_LEAF;
                        end else begin
                            op_type  <= OP_F;
                            op_stage <= op_stage - STG_W'(1);
                            state    <= ISSUE_F;
                        end
                    end
                end

                ISSUE_LEAF: begin
                    if (accepted) begin
                        op_valid <= 1'b0;
                        state    <= WAIT_U;
                    end
                end

                WAIT_U: begin
                    // The final bit needs no partial-sum fold: nothing
                    // downstream consumes it, so go straight to completion.
                    if (u_valid) begin
                        if (is_last) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            ps_valid <= 1'b1;
                            ps_u     <= u_bit;
                            ps_idx   <= bit_idx;
                            ps_depth <= count_tz(~bit_idx);
                            state    <= PS_UPD;
                        end
                    end
                end

                PS_UPD: begin
                    // The next leaf's G sits at the stage given by the
                    // trailing zeros of its index.
                    ps_valid <= 1'b0;
                    bit_idx  <= next_idx;
                    op_type  <= OP_G;
                    op_stage <= count_tz(next_idx);
                    op_valid <= 1'b1;
                    state    <= ISSUE_G;
                end

                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    op_valid <= 1'b0;
                    ps_valid <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_decode_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sc_decode_scheduler
//
// Self-checking bench for sc_decode_scheduler. A reference model builds the
// expected op sequence of a whole decode straight from the SC tree rules
// (leaf 0 descends from the root, every later leaf i starts with a G at
// stage tz(i) followed by F down to stage 0) and the expected partial-sum
// pulses from the trailing ones of each index. Handshake stalls, decision
// latency, spurious start/u_valid, abort and async reset are randomised.
// ----------------------------------------------------------------------------
module tb_sc_decode_scheduler;

    localparam int MAX_LOG_N = 9;
    localparam int STG_W     = 4;
    localparam int IDX_W     = 9;
    localparam int OP_F      = 0;
    localparam int OP_G      = 1;
    localparam int OP_LEAF   = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [STG_W-1:0] log_n = '0;
    logic             abort = 1'b0;
    logic             op_ready = 1'b0;
    logic             u_valid = 1'b0;
    logic             u_bit = 1'b0;
    logic             op_valid;
    logic [1:0]       op_type;
    logic [STG_W-1:0] op_stage;
    logic [IDX_W-1:0] bit_idx;
    logic             ps_valid;
    logic             ps_u;
    logic [STG_W-1:0] ps_depth;
    logic [IDX_W-1:0] ps_idx;
    logic             busy;
    logic             done;

    sc_decode_scheduler #(
        .MAX_LOG_N (MAX_LOG_N),
        .STG_W     (STG_W),
        .IDX_W     (IDX_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .log_n    (log_n),
        .abort    (abort),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_type  (op_type),
        .op_stage (op_stage),
        .bit_idx  (bit_idx),
        .u_valid  (u_valid),
        .u_bit    (u_bit),
        .ps_valid (ps_valid),
        .ps_u     (ps_u),
        .ps_depth (ps_depth),
        .ps_idx   (ps_idx),
        .busy     (busy),
        .done     (done)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int stage;
        int idx;
    } op_t;

    op_t exp_ops[$];
    int  u_given[512];
    int  checks = 0;
    int  errors = 0;

    function automatic int trailing_zeros(input int v);
        int t = 0;
        while (t < 32 && ((v >> t) & 1) == 0) t++;
        return t;
    endfunction

    function automatic int trailing_ones(input int v);
        int t = 0;
        while (t < 32 && ((v >> t) & 1) == 1) t++;
        return t;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drives every DUT input for the coming clock edge.
    task automatic applyStimulus(input logic st, input logic [STG_W-1:0] ln, input logic rdy,
                                 input logic uv, input logic ub, input logic ab);
        start    = st;
        log_n    = ln;
        op_ready = rdy;
        u_valid  = uv;
        u_bit    = ub;
        abort    = ab;
    endtask

    // Reference model: the full op list of one decode of size 2^n.
    task automatic buildSchedule(input int n);
        int size = 1 << n;
        exp_ops.delete();
        for (int i = 0; i < size; i++) begin
            if (i == 0) begin
                for (int s = n - 1; s >= 0; s--) exp_ops.push_back('{OP_F, s, 0});
            end else begin
                int t = trailing_zeros(i);
                exp_ops.push_back('{OP_G, t, i});
                for (int s = t - 1; s >= 0; s--) exp_ops.push_back('{OP_F, s, i});
            end
            exp_ops.push_back('{OP_LEAF, 0, i});
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_op"}, {14'd0, op_valid, op_type, op_stage, bit_idx}, 32'd0);
        checkOutput({tag, "_ps"}, {15'd0, ps_valid, ps_u, ps_depth, ps_idx}, 32'd0);
        checkOutput({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
    endtask

    // Runs one decode of size 2^n against the model. stall randomises
    // op_ready and decision latency, spur injects ignored start/u_valid,
    // abort_idx aborts while waiting on that leaf, reset_idx pulls rst_n
    // while the G of that leaf is presented (-1 disables either).
    task automatic runDecode(input int n, input bit stall, input bit spur,
                             input int abort_idx, input int reset_idx);
        int  size = 1 << n;
        int  op_ptr = 0;
        int  ps_next = 0;
        int  leaf_idx = -1;
        int  f_cnt = 0, g_cnt = 0, l_cnt = 0;
        int  cycles = 0;
        bit  waiting = 0;
        bit  finished = 0;
        bit  hold_prev = 0;
        logic [1:0]       prev_type = '0;
        logic [STG_W-1:0] prev_stage = '0;
        logic [IDX_W-1:0] prev_idx = '0;
        logic rdy, uv, ub, ab, st;
        logic [STG_W-1:0] ln;

        buildSchedule(n);
        applyStimulus(1'b1, STG_W'(n), 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("busy_after_start", busy, 1);

        while (!finished && cycles < 20000) begin
            if (hold_prev) begin
                checkOutput("stall_valid", op_valid, 1);
                checkOutput("stall_fields", {op_type, op_stage, bit_idx}, {prev_type, prev_stage, prev_idx});
            end
            if (ps_valid) begin
                checkOutput("ps_idx", ps_idx, ps_next);
                checkOutput("ps_depth", ps_depth, trailing_ones(ps_next));
                checkOutput("ps_u", ps_u, u_given[ps_next]);
                ps_next++;
            end
            if (done) begin
                checkOutput("done_all_ops", op_ptr, exp_ops.size());
                checkOutput("done_ps_count", ps_next, size - 1);
                finished = 1;
                break;
            end

            rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            uv  = 1'b0;
            ub  = 1'($urandom);
            ab  = 1'b0;
            st  = spur && ($urandom_range(0, 7) == 0);
            ln  = STG_W'($urandom_range(1, MAX_LOG_N));

            if (reset_idx >= 0 && op_valid && op_ptr < exp_ops.size() &&
                exp_ops[op_ptr].kind == OP_G && exp_ops[op_ptr].idx == reset_idx) begin
                applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
                rst_n = 1'b0;
                #1;
                checkIdleOutputs("async_reset");
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                checkIdleOutputs("after_reset_release");
                return;
            end

            if (waiting) begin
                if (leaf_idx == abort_idx) begin
                    ab = 1'b1;
                    st = 1'b0;
                end else if (!stall || $urandom_range(0, 1) == 1) begin
                    uv = 1'b1;
                    u_given[leaf_idx] = int'(ub);
                    waiting = 0;
                end
            end else if (spur) begin
                uv = 1'($urandom_range(0, 1));
            end

            if (!ab && op_valid && rdy) begin
                if (op_ptr < exp_ops.size()) begin
                    checkOutput("op_type", op_type, exp_ops[op_ptr].kind);
                    checkOutput("op_stage", op_stage, exp_ops[op_ptr].stage);
                    checkOutput("op_bit_idx", bit_idx, exp_ops[op_ptr].idx);
                    if (exp_ops[op_ptr].kind == OP_LEAF) begin
                        waiting  = 1;
                        leaf_idx = exp_ops[op_ptr].idx;
                    end
                end else begin
                    checkOutput("extra_op", op_ptr, exp_ops.size());
                end
                if (op_type == 2'd0) f_cnt++;
                else if (op_type == 2'd1) g_cnt++;
                else l_cnt++;
                op_ptr++;
            end

            hold_prev  = op_valid && !rdy && !ab;
            prev_type  = op_type;
            prev_stage = op_stage;
            prev_idx   = bit_idx;

            applyStimulus(st, ln, rdy, uv, ub, ab);
            @(posedge clk); #1;
            cycles++;

            if (ab) begin
                applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
                checkIdleOutputs("abort");
                repeat (3) begin
                    @(posedge clk); #1;
                    checkOutput("abort_no_done", {busy, done}, 0);
                end
                return;
            end
        end

        checkOutput("decode_completed", finished, 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("done_one_cycle", done, 0);
        checkOutput("busy_cleared", busy, 0);
        checkOutput("count_f", f_cnt, size - 1);
        checkOutput("count_g", g_cnt, size - 1);
        checkOutput("count_leaf", l_cnt, size);
    endtask

    // Tries a start that must be ignored and confirms nothing begins.
    task automatic tryIllegalStart(input logic [STG_W-1:0] ln);
        applyStimulus(1'b1, ln, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("illegal_start_busy", busy, 0);
        @(posedge clk); #1;
        checkOutput("illegal_start_op", op_valid, 0);
    endtask

    // Top-level sequence of scenarios.
    initial begin
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkIdleOutputs("reset_state");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkIdleOutputs("after_release");

        $display("[TB] N=4 in-order decode");
        runDecode(2, 0, 0, -1, -1);
        $display("[TB] N=8 decode with spurious inputs");
        runDecode(3, 0, 1, -1, -1);
        $display("[TB] N=2 decode");
        runDecode(1, 1, 1, -1, -1);
        $display("[TB] N=512 decode with stalls");
        runDecode(9, 1, 1, -1, -1);
        $display("[TB] abort at leaf 5 of N=16, then fresh decode");
        runDecode(4, 1, 0, 5, -1);
        runDecode(4, 1, 1, -1, -1);
        $display("[TB] illegal log_n values");
        tryIllegalStart(STG_W'(0));
        tryIllegalStart(STG_W'(10));
        tryIllegalStart(STG_W'(15));
        $display("[TB] async reset during G of leaf 3, then fresh decode");
        runDecode(3, 0, 0, -1, 3);
        runDecode(3, 1, 0, -1, -1);
        $display("[TB] random sizes");
        for (int k = 0; k < 4; k++) begin
            runDecode($urandom_range(1, 7), 1, 1, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
